// File: rtl/hazard_ctrl.sv
// hazard_ctrl: D-stage stall generation for a 5-stage pipeline.
// Tracks E/M destinations and Tnew plus mult/div busy time.
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_Tuse_rs,
    input  logic [1:0] D_Tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_Tnew,
    input  logic [1:0] D_md_op,
    output logic       stall,
    output logic       PC_WrEn,
    output logic       FD_WrEn,
    output logic       DE_flush
);

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_MULT = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] TUSE_NA = 2'd3;

    logic [4:0] e_dst;
    logic [1:0] e_tnew;
    logic [4:0] m_dst;
    logic [1:0] m_tnew;
    logic [3:0] md_cnt;
    logic       rs_haz;
    logic       rt_haz;
    logic       md_haz;

    // Operand and md-unit hazards, resolved in the same cycle
    always_comb begin
        rs_haz = 1'b0;
        rt_haz = 1'b0;
        if (D_rs_addr != 5'd0 && D_Tuse_rs != TUSE_NA) begin
            rs_haz = (e_dst == D_rs_addr && e_tnew > D_Tuse_rs) ||
                     (m_dst == D_rs_addr && m_tnew > D_Tuse_rs);
        end
        if (D_rt_addr != 5'd0 && D_Tuse_rt != TUSE_NA) begin
            rt_haz = (e_dst == D_rt_addr && e_tnew > D_Tuse_rt) ||
                     (m_dst == D_rt_addr && m_tnew > D_Tuse_rt);
        end
        md_haz   = (D_md_op != MD_NONE) && (md_cnt != 4'd0);
        stall    = rs_haz | rt_haz | md_haz;
        PC_WrEn  = ~stall;
        FD_WrEn  = ~stall;
        DE_flush = stall;
    end

    // Shadow of D/E and E/M contents; a stall pushes a bubble into E
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_dst  <= 5'd0;
            e_tnew <= 2'd0;
            m_dst  <= 5'd0;
            m_tnew <= 2'd0;
        end else begin
            if (stall) begin
                e_dst  <= 5'd0;
                e_tnew <= 2'd0;
            end else begin
                e_dst  <= D_dst;
                e_tnew <= D_Tnew;
            end
            m_dst  <= e_dst;
            m_tnew <= (e_tnew != 2'd0) ? e_tnew - 2'd1 : 2'd0;
        end
    end

    // Remaining busy cycles of the mult/div unit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            md_cnt <= 4'd0;
        end else if (!stall && D_md_op == MD_MULT) begin
            md_cnt <= 4'd5;
        end else if (!stall && D_md_op == MD_DIV) begin
            md_cnt <= 4'd10;
        end else if (md_cnt != 4'd0) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end

endmodule
